lifo_stack: RTL

Parametrised LIFO buffer with full/empty status, occupancy count, and configurable overflow policy. In overwrite mode the oldest entry is discarded when full, which suits return-address prediction. Sticky error flags record overflow and underflow. Push and pop in the same cycle replace the top entry. A one-deep pointer checkpoint supports speculative recovery. It replaces the basic stack in the front-end and is also used as a general-purpose scratch LIFO.

---
 rtl/lifo_stack.sv | 129 ++++++++++++
 1 files changed

// File: rtl/lifo_stack.sv
// Parametrised LIFO on a circular array with occupancy count, sticky error
// flags, selectable full-push policy and a one-deep pointer checkpoint.
module lifo_stack #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       flush,
    input  logic                       ckpt_save,
    input  logic                       ckpt_restore,
    input  logic                       clr_err,
    output logic [WIDTH-1:0]           data_out,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    sh_ptr_q, sh_ptr_d;
    logic [CW-1:0]    sh_count_q, sh_count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             we;
    logic [PW-1:0]    waddr;
    logic [PW-1:0]    top_idx;
    logic             empty_w, full_w;

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CW'(DEPTH));
    assign top_idx = ptr_q - PW'(1);

    always_comb begin
        ptr_d      = ptr_q;
        count_d    = count_q;
        sh_ptr_d   = sh_ptr_q;
        sh_count_d = sh_count_q;
        // Clearing happens first so a same-cycle error event still sets the flag.
        ovf_d      = clr_err ? 1'b0 : ovf_q;
        unf_d      = clr_err ? 1'b0 : unf_q;
        we         = 1'b0;
        waddr      = ptr_q;

        if (ckpt_save && !ckpt_restore) begin
            sh_ptr_d   = ptr_q;
            sh_count_d = count_q;
        end

        if (flush) begin
            ptr_d   = '0;
            count_d = '0;
        end else if (ckpt_restore) begin
            ptr_d   = sh_ptr_q;
            count_d = sh_count_q;
        end else if (push && pop) begin
            we = 1'b1;
            if (!empty_w) begin
                waddr = top_idx;
            end else begin
                ptr_d   = ptr_q + PW'(1);
                count_d = count_q + CW'(1);
                unf_d   = 1'b1;
            end
        end else if (push) begin
            if (!full_w) begin
                we      = 1'b1;
                ptr_d   = ptr_q + PW'(1);
                count_d = count_q + CW'(1);
            end else begin
                ovf_d = 1'b1;
                // Overwrite mode drops the oldest entry by advancing over it.
                if (OVERWRITE != 0) begin
                    we    = 1'b1;
                    ptr_d = ptr_q + PW'(1);
                end
            end
        end else if (pop) begin
            if (!empty_w) begin
                ptr_d   = top_idx;
                count_d = count_q - CW'(1);
            end else begin
                unf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q      <= '0;
            count_q    <= '0;
            sh_ptr_q   <= '0;
            sh_count_q <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            count_q    <= count_d;
            sh_ptr_q   <= sh_ptr_d;
            sh_count_q <= sh_count_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we && !rst) begin
            mem_q[waddr] <= data_in;
        end
    end

    assign data_out  = empty_w ? '0 : mem_q[top_idx];
    assign empty     = empty_w;
    assign full      = full_w;
    assign count     = count_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule
